// File: rtl/req_traffic_gen.sv
// req_traffic_gen: credit-bounded read-request generator over N_REGIONS buffers in stride, sequential or random mode.
module req_traffic_gen #(
  parameter int          VADDR_BITS      = 48,
  parameter int          LEN_BITS        = 28,
  parameter int          N_REGIONS       = 16,
  parameter int          CNT_BITS        = 32,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [31:0] LFSR_SEED       = 32'hFFFFFFFF
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  input  logic                              ap_abort,
  input  logic [CNT_BITS-1:0]               num_requests,
  input  logic [N_REGIONS*VADDR_BITS-1:0]   base_addr,
  input  logic [VADDR_BITS-1:0]             bound,
  input  logic [LEN_BITS-1:0]               req_size,
  input  logic [VADDR_BITS-1:0]             stride,
  input  logic [1:0]                        mode,
  output logic                              req_valid,
  input  logic                              req_ready,
  output logic [VADDR_BITS-1:0]             req_vaddr,
  output logic [LEN_BITS-1:0]               req_len,
  input  logic                              cpl_valid,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_BITS-1:0]               issued_cnt,
  output logic [CNT_BITS-1:0]               cpl_cnt
);
  localparam int RB = N_REGIONS > 1 ? $clog2(N_REGIONS) : 1;
  localparam int OB = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t                            state_q;
  logic                              start_q, pend_q, valid_q, busy_q, done_q;
  logic [31:0]                       lfsr_q;
  logic [CNT_BITS-1:0]               num_q, issued_q, cpl_q;
  logic [N_REGIONS*VADDR_BITS-1:0]   base_q;
  logic [VADDR_BITS-1:0]             bound_q, stride_q, off_q, rnd_q, vaddr_q;
  logic [LEN_BITS-1:0]               size_q;
  logic [1:0]                        mode_q;
  logic [RB-1:0]                     region_q;
  logic [OB-1:0]                     out_q;
  logic                              hs, cpl_ok, can_issue, fin;
  logic [VADDR_BITS-1:0]             size_ext, step, off_d, base_sel, rnd_d;
  logic [VADDR_BITS+1:0]             reach;
  logic [RB-1:0]                     region_d;
  logic [OB-1:0]                     out_d;
  always_comb begin
    hs        = valid_q & req_ready;
    cpl_ok    = cpl_valid & (out_q != '0);
    size_ext  = VADDR_BITS'(size_q);
    step      = (mode_q == 2'd2) ? size_ext : stride_q;
    reach     = {2'b00, off_q} + {2'b00, step} + {2'b00, size_ext};
    off_d     = (reach > {2'b00, bound_q}) ? '0 : off_q + step;
    rnd_d     = (VADDR_BITS'(lfsr_q) * size_ext) & (bound_q - VADDR_BITS'(1));
    base_sel  = base_q[int'(region_q)*VADDR_BITS +: VADDR_BITS];
    region_d  = (region_q == RB'(N_REGIONS - 1)) ? '0 : region_q + RB'(1);
    out_d     = out_q + OB'(hs) - OB'(cpl_ok);
    can_issue = (state_q == ISSUE) && (issued_q < num_q) && (out_q < OB'(MAX_OUTSTANDING))
                && !ap_abort && !valid_q && !pend_q;
    fin       = (issued_q == num_q) || (ap_abort && !valid_q);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      num_q    <= '0;
      issued_q <= '0;
      cpl_q    <= '0;
      base_q   <= '0;
      bound_q  <= '0;
      stride_q <= '0;
      off_q    <= '0;
      rnd_q    <= '0;
      vaddr_q  <= '0;
      size_q   <= '0;
      mode_q   <= '0;
      region_q <= '0;
      out_q    <= '0;
    end else begin
      start_q  <= ap_start;
      lfsr_q   <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      done_q   <= 1'b0;
      out_q    <= out_d;
      issued_q <= issued_q + CNT_BITS'(hs);
      cpl_q    <= cpl_q + CNT_BITS'(cpl_ok);
      pend_q   <= can_issue;
      if (can_issue) rnd_q <= rnd_d;
      // The request formed a cycle earlier is dropped if an abort arrives before it is raised.
      if (pend_q && state_q == ISSUE && !ap_abort) begin
        valid_q <= 1'b1;
        vaddr_q <= base_sel + ((mode_q == 2'd1) ? rnd_q : off_q);
      end
      if (hs) begin
        valid_q  <= 1'b0;
        region_q <= region_d;
        off_q    <= off_d;
      end
      case (state_q)
        IDLE: if (ap_start && !start_q) begin
          state_q  <= ISSUE;
          busy_q   <= 1'b1;
          num_q    <= num_requests;
          base_q   <= base_addr;
          bound_q  <= bound;
          stride_q <= stride;
          size_q   <= req_size;
          mode_q   <= mode;
          issued_q <= '0;
          cpl_q    <= '0;
          out_q    <= '0;
          off_q    <= '0;
          region_q <= '0;
        end
        ISSUE: if (fin) begin
          state_q <= (out_q == '0) ? IDLE : DRAIN;
          done_q  <= (out_q == '0);
          busy_q  <= (out_q != '0);
        end
        DRAIN: if (out_q == '0) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_valid  = valid_q;
  assign req_vaddr  = vaddr_q;
  assign req_len    = size_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign issued_cnt = issued_q;
  assign cpl_cnt    = cpl_q;
endmodule
